// File: rtl/register_pkg.sv
// -----------------------------------------------------------------------------
// register_pkg
// Shared constants for the generic storage register and its bus interface.
// The register itself is a self-contained leaf and does not import this
// package. Existing positional instances therefore keep working without it.
// The interface uses the package to validate its own WIDTH.
// -----------------------------------------------------------------------------
package register_pkg;

  localparam int REGISTER_MIN_WIDTH = 1;
  localparam int REGISTER_MAX_WIDTH = 64;

  // True when w is a data width the register supports.
  function automatic bit register_width_ok(input int w);
    return (w >= REGISTER_MIN_WIDTH) && (w <= REGISTER_MAX_WIDTH);
  endfunction

endpackage : register_pkg

// File: rtl/register_if.sv
// -----------------------------------------------------------------------------
// register_if
// Groups the control and data signals of one register instance.
//   reset : asynchronous active-high clear
//   load  : write enable, sampled on the rising clk edge
//   d     : data to store (WIDTH bits)
//   q     : stored value (WIDTH bits)
// The master modport drives reset/load/d and observes q.
// The slave modport is the register side.
// clk is kept outside the interface as a plain signal.
// -----------------------------------------------------------------------------
interface register_if #(
  parameter int WIDTH = 16
);
  import register_pkg::*;

  logic             reset;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  generate
    if (!register_width_ok(WIDTH)) begin : g_bad_width
      $error("register_if: WIDTH must lie in 1..64");
    end
  endgenerate

  modport master (output reset, output load, output d, input  q);
  modport slave  (input  reset, input  load, input  d, output q);

endinterface : register_if

// File: rtl/register.sv
// -----------------------------------------------------------------------------
// register
// WIDTH-bit storage register with a load enable and an asynchronous clear.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear; q goes to zero immediately
//   load  : when high at a rising clk edge, d is captured
//   d     : data in, WIDTH bits
//   q     : data out, driven directly from the flops
// The port order is fixed because existing instances connect by position.
// There is no combinational path from d or load to q.
// -----------------------------------------------------------------------------
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject unsupported widths at elaboration time.
  // This check is inlined so the block stays a standalone leaf.
  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("register: WIDTH must lie in 1..64");
    end
  endgenerate

  // Reset has priority over load. An asserted reset clears q without a clk
  // edge, which also discards any load that was pending in that cycle.
  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values. Blocking assignments here would create simulation
  // races with other clocked logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : register

// File: tb/tb_register.sv
// -----------------------------------------------------------------------------
// tb_register
// Two register instances (WIDTH=10 and WIDTH=8) are driven through
// register_if. Each instance has a reference model of its behaviour:
//   - reset forces zero,
//   - otherwise a rising edge with load high stores d,
//   - otherwise the value holds.
// A compare process checks both instances shortly after every rising edge.
// Hand-computed literal checks pin the model and cover mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  register_if #(.WIDTH(10)) bus10 ();
  register_if #(.WIDTH(8))  bus8  ();

  register #(.WIDTH(10)) dut10 (
    .clk   (clk),
    .reset (bus10.reset),
    .load  (bus10.load),
    .d     (bus10.d),
    .q     (bus10.q)
  );

  register #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (bus8.reset),
    .load  (bus8.load),
    .d     (bus8.d),
    .q     (bus8.q)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual,
               required, $time);
    end
  endtask

  // Reference models.
  // Each model value is only meaningful after that instance's first reset.
  logic [9:0] exp10;
  logic [7:0] exp8;
  bit         valid10 = 1'b0;
  bit         valid8  = 1'b0;

  always @(posedge clk) begin
    if (bus10.reset === 1'b0 && bus10.load === 1'b1) exp10 = bus10.d;
    if (bus8.reset  === 1'b0 && bus8.load  === 1'b1) exp8  = bus8.d;
  end
  always @(posedge bus10.reset) begin exp10 = '0; valid10 = 1'b1; end
  always @(posedge bus8.reset)  begin exp8  = '0; valid8  = 1'b1; end

  // Per-cycle compare, sampled away from the clock edge.
  always @(posedge clk) begin
    #2;
    if (valid10) check("q10_model", 64'(bus10.q), 64'(exp10));
    if (valid8)  check("q8_model",  64'(bus8.q),  64'(exp8));
  end

  logic [9:0] mask10;
  logic [9:0] toggled10;

  initial begin
    // Power-up reset for both instances.
    bus10.reset = 1'b1; bus10.load = 1'b0; bus10.d = '0;
    bus8.reset  = 1'b1; bus8.load  = 1'b0; bus8.d  = '0;
    repeat (2) @(negedge clk);
    check("q10_reset", 64'(bus10.q), 64'h0);
    check("q8_reset",  64'(bus8.q),  64'h0);
    bus10.reset = 1'b0;
    bus8.reset  = 1'b0;

    // WIDTH=10: load 3FF, then reset mid-cycle clears q before the next edge.
    bus10.load = 1'b1; bus10.d = 10'h3FF;
    @(negedge clk);
    check("q10_load_3ff", 64'(bus10.q), 64'h3FF);
    bus10.load = 1'b0;
    #2 bus10.reset = 1'b1;
    #1 check("q10_async_clear", 64'(bus10.q), 64'h000);
    @(negedge clk);
    bus10.reset = 1'b0;

    // WIDTH=10: capture 2A5, then hold it for 3 edges with load low.
    bus10.load = 1'b1; bus10.d = 10'h2A5;
    @(negedge clk);
    check("q10_load_2a5", 64'(bus10.q), 64'h2A5);
    bus10.load = 1'b0; bus10.d = 10'h155;
    repeat (3) @(negedge clk);
    check("q10_hold_2a5", 64'(bus10.q), 64'h2A5);

    // WIDTH=10 XOR toggle, starting from a cleared register.
    bus10.reset = 1'b1;
    @(negedge clk);
    bus10.reset = 1'b0;
    mask10 = 10'h00F;
    toggled10 = 10'h000 ^ mask10;
    bus10.load = 1'b1; bus10.d = toggled10;
    @(negedge clk);
    check("q10_xor_first", 64'(bus10.q), 64'h00F);
    toggled10 = toggled10 ^ mask10;
    bus10.d = toggled10;
    @(negedge clk);
    check("q10_xor_second", 64'(bus10.q), 64'h000);
    bus10.load = 1'b0;

    // WIDTH=8: back-to-back loads with no bubble.
    bus8.load = 1'b1; bus8.d = 8'h01;
    @(negedge clk);
    check("q8_b2b_01", 64'(bus8.q), 64'h01);
    bus8.d = 8'h80;
    @(negedge clk);
    check("q8_b2b_80", 64'(bus8.q), 64'h80);
    bus8.d = 8'hFF;
    @(negedge clk);
    check("q8_b2b_ff", 64'(bus8.q), 64'hFF);

    // WIDTH=8: reset while a load is pending wins and holds through 2 edges.
    bus8.d = 8'hC3;
    @(negedge clk);
    check("q8_load_c3", 64'(bus8.q), 64'hC3);
    bus8.d = 8'h3C;
    #2 bus8.reset = 1'b1;
    #1 check("q8_async_clear", 64'(bus8.q), 64'h00);
    @(negedge clk);
    check("q8_reset_edge1", 64'(bus8.q), 64'h00);
    @(negedge clk);
    check("q8_reset_edge2", 64'(bus8.q), 64'h00);

    // WIDTH=8: release reset, capture 5A on the first edge.
    // Then show that toggling d with load low does not change q.
    bus8.reset = 1'b0; bus8.d = 8'h5A;
    @(negedge clk);
    check("q8_first_after_reset", 64'(bus8.q), 64'h5A);
    bus8.load = 1'b0; bus8.d = 8'hA5;
    #2 bus8.d = 8'h11;
    #1 check("q8_d_toggle_midcycle", 64'(bus8.q), 64'h5A);
    @(negedge clk);
    check("q8_d_toggle_edge", 64'(bus8.q), 64'h5A);
    bus8.load = 1'b1;
    #1 check("q8_load_no_comb_path", 64'(bus8.q), 64'h5A);
    bus8.load = 1'b0;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register
